branch_predict_unit: RTL

Dynamic branch predictor and PC-source controller for the pipelined RISC-V core. It holds a parametrised table of saturating counters (BHT). The table is read in Decode to predict conditional branches. The unit carries each prediction to Execute, resolves it there, and drives the fetch PC mux select and the D/E flushes. It replaces the fixed-encoding combinational PC-source logic with a trained, parametrised predictor that also keeps performance counters.

---
 rtl/branch_predict_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Dynamic branch predictor and PC-source controller. A table of saturating
//   counters (BHT) indexed by PC[2 +: log2(BHT_ENTRIES)] predicts conditional
//   branches in Decode. The prediction is carried to Execute (BPE), resolved
//   there, and used to train the counter. The unit drives the fetch PC mux
//   select and the D/E flushes, and it keeps saturating performance counters.
//
// Ports
//   clk, reset_n            : rising-edge clock, async active-low reset
//   PCD, opD                : PC and opcode of the instruction in Decode
//   PCE, BranchE, JalrE     : PC and control of the instruction in Execute
//   TakenE                  : branch condition result in Execute
//   FlushE_i                : bubble request from the hazard unit
//   BPD                     : Decode prediction (1 = taken)
//   PCSrc                   : fetch PC mux select
//   FlushD, FlushE          : Decode / Execute register flushes
//   BrCount, MissCount      : resolved / mispredicted conditional branches
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 2,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   PCD,
  input  logic [6:0]        opD,
  input  logic [XLEN-1:0]   PCE,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              TakenE,
  input  logic              FlushE_i,
  output logic              BPD,
  output logic [2:0]        PCSrc,
  output logic              FlushD,
  output logic              FlushE,
  output logic [PERF_W-1:0] BrCount,
  output logic [PERF_W-1:0] MissCount
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_RST  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  typedef enum logic [2:0] {
    PC_PLUS4F  = 3'b000,
    PC_TARGETD = 3'b001,
    PC_JALRE   = 3'b010,
    PC_RECOVER = 3'b011,
    PC_TARGETE = 3'b100
  } pcsrc_e;

  logic [CNT_W-1:0]  r_bht [BHT_ENTRIES];
  logic              r_bpe;
  logic [PERF_W-1:0] r_br_cnt;
  logic [PERF_W-1:0] r_miss_cnt;

  logic [IDX_W-1:0]  w_idx_d;
  logic [IDX_W-1:0]  w_idx_e;
  logic [CNT_W-1:0]  w_cnt_d;
  logic [CNT_W-1:0]  w_cnt_e;
  logic              w_bpd;
  logic              w_bre;
  logic              w_miss_t;
  logic              w_miss_nt;
  logic              w_flush_e;
  pcsrc_e            w_pcsrc;
  logic              w_unused_pc;

  // Only the index bits of the PCs are meaningful here.
  assign w_unused_pc = ^{PCD, PCE};

  assign w_idx_d = PCD[2 +: IDX_W];
  assign w_idx_e = PCE[2 +: IDX_W];
  assign w_cnt_d = r_bht[w_idx_d];
  assign w_cnt_e = r_bht[w_idx_e];

  // Decode read returns the registered value: a same-cycle E update to the
  // same entry becomes visible only on the following cycle.
  always_comb begin
    w_bpd = 1'b0;
    if (opD == OP_JAL)
      w_bpd = 1'b1;
    else if (opD == OP_BRANCH)
      w_bpd = w_cnt_d[CNT_W-1];
  end

  assign w_bre     = BranchE & ~JalrE;
  assign w_miss_t  = w_bre &  r_bpe & ~TakenE;
  assign w_miss_nt = w_bre & ~r_bpe &  TakenE;

  // Execute redirects take precedence over the Decode prediction.
  always_comb begin
    w_pcsrc = PC_PLUS4F;
    if (JalrE)
      w_pcsrc = PC_JALRE;
    else if (w_miss_t)
      w_pcsrc = PC_RECOVER;
    else if (w_miss_nt)
      w_pcsrc = PC_TARGETE;
    else if (w_bpd)
      w_pcsrc = PC_TARGETD;
  end

  assign w_flush_e = (w_pcsrc == PC_JALRE) | (w_pcsrc == PC_RECOVER) |
                     (w_pcsrc == PC_TARGETE);

  assign BPD       = w_bpd;
  assign PCSrc     = w_pcsrc;
  assign FlushE    = w_flush_e;
  assign FlushD    = (w_pcsrc != PC_PLUS4F);
  assign BrCount   = r_br_cnt;
  assign MissCount = r_miss_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bpe <= 1'b0;
    end else if (FlushE_i || w_flush_e) begin
      r_bpe <= 1'b0;
    end else begin
      r_bpe <= w_bpd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++)
        r_bht[i] <= CNT_RST;
    end else if (w_bre) begin
      if (TakenE) begin
        if (w_cnt_e != '1)
          r_bht[w_idx_e] <= w_cnt_e + CNT_ONE;
      end else begin
        if (w_cnt_e != '0)
          r_bht[w_idx_e] <= w_cnt_e - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_bre && (r_br_cnt != '1))
        r_br_cnt <= r_br_cnt + PERF_ONE;
      if ((w_miss_t || w_miss_nt) && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + PERF_ONE;
    end
  end

endmodule
